// File: rtl/fma16.sv
// Binary16 fused multiply-add: result = +/-(x*y) +/- z with a single rounding step.
// Combinational datapath with the result and flags registered, for one-cycle latency.
module fma16 (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] z,
   input  logic        mul,
   input  logic        add,
   input  logic        negp,
   input  logic        negz,
   input  logic [1:0]  roundmode,
   output logic [15:0] result,
   output logic [3:0]  flags
);

   logic [15:0] yv, zv;
   logic [4:0]  xe, ye, ze, ex, ey, ez;
   logic [9:0]  xf, yf, zf;
   logic [10:0] mx, my, mz;
   logic        xnan, ynan, znan, xsnan, ysnan, zsnan;
   logic        xinf, yinf, zinf, xzero, yzero, zzero;
   logic        sp, sz, pinf, pzero, anynan, invalid, toinf;

   assign yv = mul ? y : 16'h3C00;
   assign zv = add ? z : 16'h0000;

   assign {xe, xf} = x[14:0];
   assign {ye, yf} = yv[14:0];
   assign {ze, zf} = zv[14:0];

   assign xnan  = (xe == 5'h1F) && (xf != 10'd0);
   assign ynan  = (ye == 5'h1F) && (yf != 10'd0);
   assign znan  = (ze == 5'h1F) && (zf != 10'd0);
   assign xsnan = xnan && !xf[9];
   assign ysnan = ynan && !yf[9];
   assign zsnan = znan && !zf[9];
   assign xinf  = (xe == 5'h1F) && (xf == 10'd0);
   assign yinf  = (ye == 5'h1F) && (yf == 10'd0);
   assign zinf  = (ze == 5'h1F) && (zf == 10'd0);
   assign xzero = (x[14:0] == 15'd0);
   assign yzero = (yv[14:0] == 15'd0);
   assign zzero = (zv[14:0] == 15'd0);

   // Subnormals share the minimum exponent and simply lose the hidden bit.
   assign mx = {xe != 5'd0, xf};
   assign my = {ye != 5'd0, yf};
   assign mz = {ze != 5'd0, zf};
   assign ex = (xe == 5'd0) ? 5'd1 : xe;
   assign ey = (ye == 5'd0) ? 5'd1 : ye;
   assign ez = (ze == 5'd0) ? 5'd1 : ze;

   assign sp      = x[15] ^ yv[15] ^ negp;
   assign sz      = zv[15] ^ negz;
   assign pinf    = (xinf || yinf) && !xnan && !ynan;
   assign pzero   = xzero || yzero;
   assign anynan  = xnan || ynan || znan;
   assign invalid = xsnan || ysnan || zsnan || (xinf && yzero) || (xzero && yinf) ||
                    (pinf && zinf && (sp != sz));

   logic [21:0] prodm;
   logic [5:0]  shp, shz;
   logic [81:0] pm, zm, sum;
   logic        ss, guard, sticky, inexact, up;
   logic [6:0]  lead, lpos;
   logic [10:0] kept;
   logic [16:0] enc;

   // Both operands are placed in one fixed-point word whose lsb is 2^-48, so the
   // sum is exact and rounding sees every discarded bit.
   always_comb begin
      prodm = {11'd0, mx} * {11'd0, my};
      shp   = {1'b0, ex} + {1'b0, ey} - 6'd2;
      shz   = {1'b0, ez} + 6'd23;
      pm    = {60'd0, prodm} << shp;
      zm    = {71'd0, mz} << shz;
      if (sp == sz) begin
         sum = pm + zm;
         ss  = sp;
      end else if (pm >= zm) begin
         sum = pm - zm;
         ss  = sp;
      end else begin
         sum = zm - pm;
         ss  = sz;
      end
      lead = 7'd0;
      for (int i = 0; i < 82; i++) begin
         if (sum[i]) lead = 7'(i);
      end
      // Below 2^-14 the kept lsb pins at 2^-24, which yields subnormal encodings for free.
      lpos    = (lead >= 7'd34) ? lead - 7'd10 : 7'd24;
      kept    = 11'(sum >> lpos);
      guard   = sum[lpos - 7'd1];
      sticky  = |(sum << (7'd83 - lpos));
      inexact = guard | sticky;
      case (roundmode)
         2'b00:   up = 1'b0;
         2'b01:   up = guard & (sticky | kept[0]);
         2'b10:   up = ss & inexact;
         default: up = !ss & inexact;
      endcase
      // A rounding carry out of the significand ripples straight into the exponent field.
      enc = {lpos - 7'd24, 10'd0} + {6'd0, kept} + {16'd0, up};
   end

   logic [15:0] nres;
   logic [3:0]  nflags;

   assign toinf = (roundmode == 2'b01) || ((roundmode == 2'b11) && !ss) ||
                  ((roundmode == 2'b10) && ss);

   always_comb begin
      nres   = 16'h0000;
      nflags = 4'b0000;
      if (invalid) begin
         nres   = 16'h7E00;
         nflags = 4'b1000;
      end else if (anynan) begin
         nres = 16'h7E00;
      end else if (pinf) begin
         nres = {sp, 15'h7C00};
      end else if (zinf) begin
         nres = {sz, 15'h7C00};
      end else if (sum == 82'd0) begin
         if (!add || (pzero && zzero && (sp == sz)))
            nres = {sp, 15'h0000};
         else
            nres = {roundmode == 2'b10, 15'h0000};
      end else if (enc >= 17'h07C00) begin
         nres   = toinf ? {ss, 15'h7C00} : {ss, 15'h7BFF};
         nflags = 4'b0101;
      end else begin
         nres   = {ss, enc[14:0]};
         nflags = {2'b00, inexact && (enc < 17'h00400), inexact};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         result <= 16'h0000;
         flags  <= 4'b0000;
      end else begin
         result <= nres;
         flags  <= nflags;
      end
   end

endmodule

// File: tb/tb_fma16.sv
// Bench for fma16: directed cases plus random vectors scored against an exact-integer reference model.
module tb_fma16;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] x, y, z;
   logic        mul, add, negp, negz;
   logic [1:0]  roundmode;
   logic [15:0] result;
   logic [3:0]  flags;

   int assertCount = 0;
   int failCount   = 0;

   logic [15:0] specials [10] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                                  16'h7D00, 16'h0001, 16'h7BFF, 16'h03FF, 16'h0400};

   fma16 dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .z(z), .mul(mul), .add(add),
      .negp(negp), .negz(negz), .roundmode(roundmode), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   function automatic logic isNan(input logic [15:0] h);
      return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
   endfunction

   function automatic logic isSnan(input logic [15:0] h);
      return isNan(h) && !h[9];
   endfunction

   function automatic logic isInf(input logic [15:0] h);
      return (h[14:10] == 5'h1F) && (h[9:0] == 10'd0);
   endfunction

   function automatic logic isZero(input logic [15:0] h);
      return h[14:0] == 15'd0;
   endfunction

   // Magnitude of a finite half as an integer count of 2^-48 units.
   function automatic logic [95:0] magOf(input logic [15:0] h);
      if (h[14:10] == 5'd0) return {86'd0, h[9:0]} << 24;
      return {85'd0, 1'b1, h[9:0]} << (h[14:10] + 23);
   endfunction

   function automatic int msbOf(input logic [95:0] v);
      for (int i = 95; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic refModel(input logic [15:0] ix, iy, iz, input logic im, ia, inp, inz,
                           input logic [1:0] irm, output logic [15:0] r, output logic [3:0] f);
      logic [15:0] hy, hz;
      logic [191:0] prod;
      logic signed [97:0] pVal, zVal, total;
      logic [95:0] v, q, rem, half, rr;
      logic sp, sz, s, inex, up, pInf, toInf;
      int k, e, bexp;
      hy = im ? iy : 16'h3C00;
      hz = ia ? iz : 16'h0000;
      sp = ix[15] ^ hy[15] ^ inp;
      sz = hz[15] ^ inz;
      pInf = (isInf(ix) || isInf(hy)) && !isNan(ix) && !isNan(hy);
      r = 16'h0000;
      f = 4'b0000;
      if (isSnan(ix) || isSnan(hy) || isSnan(hz) || (isInf(ix) && isZero(hy)) ||
          (isZero(ix) && isInf(hy)) || (pInf && isInf(hz) && sp != sz)) begin
         r = 16'h7E00;
         f = 4'b1000;
      end else if (isNan(ix) || isNan(hy) || isNan(hz)) begin
         r = 16'h7E00;
      end else if (pInf) begin
         r = {sp, 15'h7C00};
      end else if (isInf(hz)) begin
         r = {sz, 15'h7C00};
      end else begin
         prod  = {96'd0, magOf(ix)} * {96'd0, magOf(hy)};
         pVal  = $signed({2'b00, 96'(prod >> 48)});
         zVal  = $signed({2'b00, magOf(hz)});
         total = (sp ? -pVal : pVal) + (sz ? -zVal : zVal);
         s     = total < 0;
         v     = 96'(s ? -total : total);
         if (v == 96'd0) begin
            if (!ia || (isZero(ix) || isZero(hy)) && isZero(hz) && sp == sz) r = {sp, 15'h0};
            else r = {irm == 2'b10, 15'h0};
         end else begin
            k    = (v < (96'd1 << 34)) ? 24 : msbOf(v) - 10;
            q    = v >> k;
            rem  = v - (q << k);
            half = 96'd1 << (k - 1);
            inex = rem != 96'd0;
            case (irm)
               2'b00:   up = 1'b0;
               2'b01:   up = (rem > half) || (rem == half && q[0]);
               2'b10:   up = s && inex;
               default: up = !s && inex;
            endcase
            rr = (q + {95'd0, up}) << k;
            toInf = (irm == 2'b01) || (irm == 2'b11 && !s) || (irm == 2'b10 && s);
            if (rr < (96'd1 << 34)) begin
               r = {s, 5'd0, 10'(rr >> 24)};
               f = {2'b00, inex, inex};
            end else begin
               e    = msbOf(rr);
               bexp = e - 33;
               if (bexp > 30) begin
                  r = toInf ? {s, 15'h7C00} : {s, 15'h7BFF};
                  f = 4'b0101;
               end else begin
                  r = {s, 5'(bexp), 10'(rr >> (e - 10))};
                  f = {3'b000, inex};
               end
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [15:0] ax, ay, az, input logic am, aa, anp, anz,
                                input logic [1:0] arm);
      @(negedge clk);
      x = ax; y = ay; z = az;
      mul = am; add = aa; negp = anp; negz = anz; roundmode = arm;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] expR, input logic [3:0] expF);
      assertCount++;
      assert (result === expR) else begin
         failCount++;
         $error("[TB] FAIL %s result: observed %h expected %h", tag, result, expR);
      end
      assertCount++;
      assert (flags === expF) else begin
         failCount++;
         $error("[TB] FAIL %s flags: observed %b expected %b", tag, flags, expF);
      end
   endtask

   function automatic logic [15:0] pickHalf();
      if ($urandom_range(0, 5) == 0) return specials[$urandom_range(0, 9)];
      return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom_range(0, 1023))};
   endfunction

   initial begin
      logic [15:0] rx, ry, rz, expR;
      logic [3:0]  expF;
      logic        rm, ra, rnp, rnz;
      logic [1:0]  rrm;

      reset = 1'b0;
      applyStimulus(16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      @(posedge clk); #1;
      checkOutput("reset", 16'h0000, 4'b0000);
      reset = 1'b1;

      applyStimulus(16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("one_x_one", 16'h3C00, 4'b0000);
      applyStimulus(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
      checkOutput("fma_3", 16'h4200, 4'b0000);
      applyStimulus(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
      checkOutput("fma_negp", 16'hBC00, 4'b0000);
      applyStimulus(16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("round_rne", 16'h3C02, 4'b0001);
      applyStimulus(16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      checkOutput("round_rz", 16'h3C02, 4'b0001);
      applyStimulus(16'h3C01, 16'h3C01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
      checkOutput("round_rp", 16'h3C03, 4'b0001);
      applyStimulus(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("ovf_rne", 16'h7C00, 4'b0101);
      applyStimulus(16'h7BFF, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      checkOutput("ovf_rz", 16'h7BFF, 4'b0101);
      applyStimulus(16'h7C00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("inf_x_zero", 16'h7E00, 4'b1000);
      applyStimulus(16'h7C00, 16'h3C00, 16'h7C00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
      checkOutput("inf_minus_inf", 16'h7E00, 4'b1000);
      applyStimulus(16'h7E00, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("qnan_in", 16'h7E00, 4'b0000);
      applyStimulus(16'h3C00, 16'h3C00, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
      checkOutput("cancel_rne", 16'h0000, 4'b0000);
      applyStimulus(16'h3C00, 16'h3C00, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
      checkOutput("cancel_rm", 16'h8000, 4'b0000);
      applyStimulus(16'h0400, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("subnorm_exact", 16'h0200, 4'b0000);
      applyStimulus(16'h0001, 16'h3800, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("underflow", 16'h0000, 4'b0011);
      applyStimulus(16'h4000, 16'h7D00, 16'h7D00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("ignored_snan", 16'h4000, 4'b0000);
      applyStimulus(16'h8000, 16'h3C00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
      checkOutput("neg_zero_prod", 16'h8000, 4'b0000);
      applyStimulus(16'h0000, 16'h4000, 16'hB555, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
      checkOutput("zero_prod_addend", 16'hB555, 4'b0000);

      reset = 1'b0;
      applyStimulus(16'h3C00, 16'h4000, 16'h3C00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
      checkOutput("reset_override", 16'h0000, 4'b0000);
      reset = 1'b1;

      for (int n = 0; n < 400; n++) begin
         rx  = pickHalf();
         ry  = pickHalf();
         rz  = pickHalf();
         rm  = 1'($urandom_range(0, 3) != 0);
         ra  = 1'($urandom_range(0, 3) != 0);
         rnp = 1'($urandom_range(0, 1));
         rnz = 1'($urandom_range(0, 1));
         rrm = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) begin
            rm  = 1'b0;
            ra  = 1'b1;
            rz  = rx ^ {15'd0, 1'($urandom_range(0, 1))};
            rnz = ~rnp;
         end
         refModel(rx, ry, rz, rm, ra, rnp, rnz, rrm, expR, expF);
         applyStimulus(rx, ry, rz, rm, ra, rnp, rnz, rrm);
         checkOutput($sformatf("rand%0d x=%h y=%h z=%h m=%b a=%b np=%b nz=%b rm=%0d",
                               n, rx, ry, rz, rm, ra, rnp, rnz, rrm), expR, expF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fma16.md
Name: fma16

Overview:
- IEEE 754 binary16 (half-precision) fused multiply-add: result = ±(x·y) ± z with a single rounding.
- Mode inputs reduce the operation to multiply-only or add-only.
- Arithmetic datapath is combinational; result and flags are registered, giving a single-cycle-latency unit.
- Sits as a standalone FP arithmetic block driven by a vector-based bench.

Parameters:
- none (format fixed: 1 sign, 5 exponent bits with bias 15, 10 fraction bits)

Ports:
- clk  in  1  clock; outputs update on rising edge
- reset  in  1  synchronous, active-low reset
- x  in  16  multiplicand (binary16)
- y  in  16  multiplier (binary16)
- z  in  16  addend (binary16)
- mul  in  1  1: use y; 0: y treated as +1.0 (0x3C00)
- add  in  1  1: use z; 0: z treated as +0.0
- negp  in  1  negate product
- negz  in  1  negate addend
- roundmode  in  2  00 RZ (toward zero), 01 RNE, 10 RM (toward −inf), 11 RP (toward +inf)
- result  out  16  registered binary16 result
- flags  out  4  registered {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: when reset=0 at a rising clk edge, result←0x0000 and flags←0000. This overrides any computation.
- Otherwise each rising edge registers f(inputs sampled at that edge). Latency is 1 cycle, throughput 1 per cycle, no handshake.
- Operation: P = (negp ? −1 : 1)·x·y′; Z′ = (negz ? −1 : 1)·z″.
  - y′ = mul ? y : 1.0; z″ = add ? z : +0.
  - R = round(P + Z′) with exact intermediate (no double rounding).
- Subnormal inputs are fully supported (hidden bit 0, exponent 1−15). Subnormal outputs are produced when representable.
- Rounding:
  - Guard/round/sticky are computed from the full-precision sum.
  - RNE ties go to even.
  - RZ truncates.
  - RM/RP round by direction according to the sign.
- Overflow: on overflow of the rounded exponent, set overflow and inexact.
  - Result is ±inf (0x7C00/0xFC00) for RNE, and for RP when positive or RM when negative.
  - Otherwise the result is ±max finite (0x7BFF/0xFBFF).
- Underflow: set when the result is tiny (nonzero, |R| < 2^−14 after rounding) and inexact.
- Inexact: set when the rounded result differs from the exact value.
- Invalid: set, with result = canonical NaN 0x7E00, for:
  - any signalling-NaN input (exp=31, frac≠0, frac[9]=0);
  - inf·0;
  - inf − inf (product inf vs addend inf of opposite effective sign).
- Quiet-NaN inputs: result 0x7E00, no flags.
- Infinity propagation:
  - inf product or inf addend (non-conflicting) gives correctly signed inf, flags 0000.
  - Inf results from finite operands arise only via overflow.
- Exact zero sum:
  - P and Z′ are both zeros of the same sign: result keeps that sign.
  - Otherwise an exact zero (including cancellation) is +0, except −0 in RM.
- x·y exactly zero with a nonzero addend: result = Z′ exactly, no flags.
- Ignored-operand handling:
  - mul=0: y contents are ignored, including NaN.
  - add=0: z contents are ignored, including NaN.
  - With add=0, the result is ±x·y rounded; a zero product keeps its sign (x·y sign XOR negp).
- Flags reflect only the operation in the same cycle. They are not sticky.

Test Plan:
- reset=0 for 2 edges with x=0x3C00, y=0x3C00 -> result 0x0000, flags 0000. Release reset; 0x3C00·0x3C00, mul=1, add=0, RNE -> next edge 0x3C00, flags 0000.
- FMA: x=0x3C00, y=0x4000, z=0x3C00, mul=add=1, RNE -> 0x4200 (3.0), flags 0000. Same with negp=1 -> 0xBC00 (−1.0).
- Rounding: x=y=0x3C01, mul=1, add=0 -> RNE 0x3C02 flags 0001; RZ 0x3C02; RP 0x3C03.
- Overflow: x=0x7BFF, y=0x4000, mul=1, add=0 -> RNE 0x7C00 flags 0101; RZ 0x7BFF flags 0101.
- Specials:
  - x=0x7C00, y=0x0000 -> 0x7E00 flags 1000.
  - x=0x7C00, y=0x3C00, z=0x7C00, negz=1, add=1 -> 0x7E00 flags 1000.
  - x=0x7E00 (qNaN) -> 0x7E00 flags 0000.
- Cancellation/subnormal:
  - x=y=z=0x3C00, negz=1, add=1 -> RNE 0x0000, RM 0x8000.
  - x=0x0400, y=0x3800, mul=1, add=0 -> 0x0200 flags 0000 (exact subnormal).
  - x=0x0001, y=0x3800 -> RNE 0x0000 flags 0011.
